// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache: address field layout,
// storage geometry and controller state encoding.
package dcache_pkg;

  localparam int TAG_W      = 3;
  localparam int INDEX_W    = 3;
  localparam int OFFSET_W   = 2;
  localparam int ADDR_W     = TAG_W + INDEX_W + OFFSET_W;
  localparam int BYTE_W     = 8;
  localparam int BLOCK_W    = BYTE_W << OFFSET_W;
  localparam int LINES      = 1 << INDEX_W;
  localparam int MEM_ADDR_W = TAG_W + INDEX_W;

  // Slice positions of the CPU byte address fields.
  localparam int OFFSET_LSB = 0;
  localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;
  localparam int TAG_LSB    = INDEX_LSB + INDEX_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2,
    ST_UPDATE    = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache: data, tag, valid and dirty per line, with
// hit compare, byte-select read, single-byte write and whole-block fill.
module dcache_array
  import dcache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  i_index,
  input  logic [TAG_W-1:0]    i_tag,
  input  logic [OFFSET_W-1:0] i_offset,
  input  logic                i_byte_we,
  input  logic [BYTE_W-1:0]   i_byte_wdata,
  input  logic                i_fill_we,
  input  logic [BLOCK_W-1:0]  i_fill_data,
  output logic                o_hit,
  output logic [BYTE_W-1:0]   o_rbyte,
  output logic                o_line_valid,
  output logic                o_line_dirty,
  output logic [TAG_W-1:0]    o_line_tag,
  output logic [BLOCK_W-1:0]  o_line_data
);

  logic [BLOCK_W-1:0] r_data [LINES];
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [LINES-1:0]   r_valid;
  logic [LINES-1:0]   r_dirty;

  logic [OFFSET_W+2:0] w_bit_lsb;

  assign w_bit_lsb    = {i_offset, 3'b000};
  assign o_line_valid = r_valid[i_index];
  assign o_line_dirty = r_dirty[i_index];
  assign o_line_tag   = r_tag[i_index];
  assign o_line_data  = r_data[i_index];
  assign o_hit        = r_valid[i_index] && (r_tag[i_index] == i_tag);
  assign o_rbyte      = o_line_data[w_bit_lsb +: BYTE_W];

  // Line status: reset invalidates everything; a fill makes the line clean, a store dirties it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_we) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= 1'b0;
    end else if (i_byte_we) begin
      r_dirty[i_index] <= 1'b1;
    end
  end

  // Data and tag arrays carry no reset; they are only meaningful under a set valid bit.
  always_ff @(posedge clk) begin
    if (i_fill_we) begin
      r_data[i_index] <= i_fill_data;
      r_tag[i_index]  <= i_tag;
    end else if (i_byte_we) begin
      r_data[i_index][w_bit_lsb +: BYTE_W] <= i_byte_wdata;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate direct-mapped data cache controller. Hits are
// served combinationally in IDLE; misses run WRITEBACK (dirty victim only),
// FETCH and a one-cycle UPDATE before the request is retried as a hit.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_W-1:0]     ADDRESS,
  input  logic [BYTE_W-1:0]     WRITEDATA,
  output logic [BYTE_W-1:0]     READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_req_held;
  logic [TAG_W-1:0]     r_miss_tag;
  logic [INDEX_W-1:0]   r_miss_idx;
  logic [BLOCK_W-1:0]   r_fill_data;

  logic                 w_req;
  logic                 w_idle;
  logic                 w_done;
  logic                 w_mem_req;
  logic                 w_byte_we;
  logic                 w_fill_we;
  logic [TAG_W-1:0]     w_addr_tag;
  logic [INDEX_W-1:0]   w_addr_idx;
  logic [OFFSET_W-1:0]  w_addr_off;
  logic [TAG_W-1:0]     w_cmp_tag;
  logic [INDEX_W-1:0]   w_idx;
  logic                 w_hit;
  logic [BYTE_W-1:0]    w_rbyte;
  logic                 w_line_valid;
  logic                 w_line_dirty;
  logic [TAG_W-1:0]     w_line_tag;
  logic [BLOCK_W-1:0]   w_line_data;

  assign w_req      = READ | WRITE;
  assign w_idle     = (r_state == ST_IDLE);
  assign w_addr_tag = ADDRESS[TAG_LSB +: TAG_W];
  assign w_addr_idx = ADDRESS[INDEX_LSB +: INDEX_W];
  assign w_addr_off = ADDRESS[OFFSET_LSB +: OFFSET_W];
  // During a miss the latched line is used so the fill cannot be redirected
  // by a CPU that drops or changes its request.
  assign w_idx      = w_idle ? w_addr_idx : r_miss_idx;
  assign w_cmp_tag  = w_idle ? w_addr_tag : r_miss_tag;
  // A memory transaction completes only once the request has been visible for a full cycle.
  assign w_done     = r_req_held & ~MEM_BUSYWAIT;

  dcache_array u_array (
    .clk          (CLK),
    .rst_n        (RESET),
    .i_index      (w_idx),
    .i_tag        (w_cmp_tag),
    .i_offset     (w_addr_off),
    .i_byte_we    (w_byte_we),
    .i_byte_wdata (WRITEDATA),
    .i_fill_we    (w_fill_we),
    .i_fill_data  (r_fill_data),
    .o_hit        (w_hit),
    .o_rbyte      (w_rbyte),
    .o_line_valid (w_line_valid),
    .o_line_dirty (w_line_dirty),
    .o_line_tag   (w_line_tag),
    .o_line_data  (w_line_data)
  );

  // Next-state and all CPU/memory-side outputs, decoded from state and line contents.
  always_comb begin
    w_next_state  = r_state;
    READDATA      = 8'h00;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'h00;
    MEM_WRITEDATA = 32'h0000_0000;
    w_mem_req     = 1'b0;
    w_byte_we     = 1'b0;
    w_fill_we     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          READDATA = w_rbyte;
        end else begin
          READDATA = 8'h00;
        end
        BUSYWAIT  = w_req & ~w_hit;
        w_byte_we = WRITE & w_hit;
        if (w_req && !w_hit) begin
          if (w_line_valid && w_line_dirty) begin
            w_next_state = ST_WRITEBACK;
          end else begin
            w_next_state = ST_FETCH;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {w_line_tag, r_miss_idx};
        MEM_WRITEDATA = w_line_data;
        w_mem_req     = 1'b1;
        if (w_done) begin
          w_next_state = ST_FETCH;
        end else begin
          w_next_state = ST_WRITEBACK;
        end
      end
      ST_FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {r_miss_tag, r_miss_idx};
        w_mem_req   = 1'b1;
        if (w_done) begin
          w_next_state = ST_UPDATE;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_UPDATE: begin
        BUSYWAIT     = 1'b1;
        w_fill_we    = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register and the "request already visible last cycle" flag.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_req_held <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_req_held <= w_mem_req & ~w_done;
    end
  end

  // Miss bookkeeping: latch the missing line on detection and the fetched block on completion.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_miss_tag  <= 3'd0;
      r_miss_idx  <= 3'd0;
      r_fill_data <= 32'h0000_0000;
    end else begin
      if (w_idle && w_req && !w_hit) begin
        r_miss_tag <= w_addr_tag;
        r_miss_idx <= w_addr_idx;
      end
      if ((r_state == ST_FETCH) && w_done) begin
        r_fill_data <= MEM_READDATA;
      end
    end
  end

endmodule
